// File: rtl/dbus_uart_tx.sv
// ============================================================================
// Module   : dbus_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter on the CPU data bus, with a
//            small transmit FIFO and a programmable bit period.
//            Optional even-parity bit: define DBUS_UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hff00,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic        dwrite_en,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  output logic        dread_hit,
  output logic        txd
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
  localparam logic [1:0]      OFF_TXDATA = 2'd0;
  localparam logic [1:0]      OFF_STATUS = 2'd1;
  localparam logic [1:0]      OFF_DIV    = 2'd2;

`ifdef DBUS_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   frame_div_q, frame_div_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          txd_q, txd_d;
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic          wr_hit_w, push_req_w, push_w, drop_w, pop_w;
  logic          full_w, empty_w, tmr_done_w;
  logic [7:0]    head_w;
  logic [15:0]   status_w;
  logic          unused_w;

  assign wr_hit_w   = dwrite_en && (dwrite_addr[15:3] == BASE_ADDR[15:3]);
  assign push_req_w = wr_hit_w && (dwrite_addr[2:1] == OFF_TXDATA);
  assign full_w     = (count_q == FULL_CNT);
  assign empty_w    = (count_q == '0);
  // Fullness is judged before the edge, so a same-edge pop cannot rescue a push.
  assign push_w     = push_req_w && !full_w;
  assign drop_w     = push_req_w && full_w;
  assign head_w     = fifo_q[rd_ptr_q];
  assign tmr_done_w = (timer_q == 16'd0);
  assign txd        = txd_q;
  assign unused_w   = ^{dwrite_addr[0], dread_addr[0], parity_q};

  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_hit_w && (dwrite_addr[2:1] == OFF_DIV)) div_d = dwrite_data;
    if (wr_hit_w && (dwrite_addr[2:1] == OFF_STATUS) && dwrite_data[3]) ovf_d = 1'b0;
    if (drop_w) ovf_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    frame_div_d = frame_div_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    txd_d       = txd_q;
    pop_w       = 1'b0;
    // Frame start from IDLE or straight out of an expiring STOP (no idle gap).
    if (!empty_w && (state_q == IDLE || (state_q == STOP && tmr_done_w))) begin
      pop_w       = 1'b1;
      shift_d     = head_w;
      parity_d    = ^head_w;
      frame_div_d = div_q;
      timer_d     = div_q;
      bitcnt_d    = 3'd0;
      state_d     = START;
      txd_d       = 1'b0;
    end else if (state_q != IDLE) begin
      if (!tmr_done_w) begin
        timer_d = timer_q - 16'd1;
      end else begin
        timer_d = frame_div_q;
        case (state_q)
          START: begin
            state_d = DATA;
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
          DATA: begin
            if (bitcnt_q == 3'd7) begin
`ifdef DBUS_UART_TX_PARITY_EN
              state_d = PARITY;
              txd_d   = parity_q;
`else
              state_d = STOP;
              txd_d   = 1'b1;
`endif
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
              txd_d    = shift_q[0];
              shift_d  = {1'b0, shift_q[7:1]};
            end
          end
`ifdef DBUS_UART_TX_PARITY_EN
          PARITY: begin
            state_d = STOP;
            txd_d   = 1'b1;
          end
`endif
          default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      frame_div_q <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      txd_q       <= 1'b1;
      div_q       <= DIV_RESET;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      frame_div_q <= frame_div_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      txd_q       <= txd_d;
      div_q       <= div_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_w) begin
        fifo_q[wr_ptr_q] <= dwrite_data[7:0];
        wr_ptr_q         <= wr_ptr_q + PTR_ONE;
      end
      if (pop_w) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_w && !pop_w)      count_q <= count_q + CNT_ONE;
      else if (!push_w && pop_w) count_q <= count_q - CNT_ONE;
    end
  end

  always_comb begin
    status_w             = '0;
    status_w[0]          = full_w;
    status_w[1]          = empty_w;
    status_w[2]          = (state_q != IDLE);
    status_w[3]          = ovf_q;
`ifdef DBUS_UART_TX_PARITY_EN
    status_w[4]          = 1'b1;
`endif
    status_w[8 +: AW+1]  = count_q;
    dread_hit  = (dread_addr[15:3] == BASE_ADDR[15:3]);
    dread_data = '0;
    if (dread_hit) begin
      case (dread_addr[2:1])
        OFF_STATUS: dread_data = status_w;
        OFF_DIV:    dread_data = div_q;
        default:    dread_data = '0;
      endcase
    end
  end

endmodule

`default_nettype wire
